// File: rtl/numeric_entry_ctrl.sv
// Multi-digit decimal entry from PS/2 make/break events, with press-lock, backspace and clear,
// plus BCD-to-binary conversion and range check on Enter. Optional idle auto-clear: ENTRY_TIMEOUT_EN.
module numeric_entry_ctrl #(
    parameter int NUM_DIGITS     = 2,
    parameter int VALUE_W        = 7,
    parameter int MIN_VALUE      = 1,
    parameter int MAX_VALUE      = 25,
    parameter int FULL_MODE      = 0,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              key_valid,
    input  logic [8:0]                        key_code,
    input  logic                              key_make,
    output logic [4*NUM_DIGITS-1:0]           entry_bcd,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              busy,
    output logic [VALUE_W-1:0]                value_out,
    output logic                              value_valid,
    output logic                              value_err
);

    localparam int EW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int AW = VALUE_W + 4;
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_DIGITS);
    localparam logic [AW-1:0] MIN_A    = AW'(MIN_VALUE);
    localparam logic [AW-1:0] MAX_A    = AW'(MAX_VALUE);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be in 1..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        CHECK   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_NONE  = 3'd0,
        K_DIGIT = 3'd1,
        K_ENTER = 3'd2,
        K_BS    = 3'd3,
        K_ESC   = 3'd4
    } key_kind_t;

    state_t          state;
    key_kind_t       key_kind;
    logic [3:0]      key_digit;
    logic            locked;
    logic [8:0]      lock_code;
    logic            accept;
    logic [EW-1:0]   shift_in;
    logic [EW-1:0]   conv_sr;
    logic [CW-1:0]   conv_cnt;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_next;

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]   idle_cnt;
`endif

    always_comb begin
        key_kind  = K_NONE;
        key_digit = 4'd0;
        case (key_code)
            9'h045, 9'h070: begin key_kind = K_DIGIT; key_digit = 4'd0; end
            9'h016, 9'h069: begin key_kind = K_DIGIT; key_digit = 4'd1; end
            9'h01E, 9'h072: begin key_kind = K_DIGIT; key_digit = 4'd2; end
            9'h026, 9'h07A: begin key_kind = K_DIGIT; key_digit = 4'd3; end
            9'h025, 9'h06B: begin key_kind = K_DIGIT; key_digit = 4'd4; end
            9'h02E, 9'h073: begin key_kind = K_DIGIT; key_digit = 4'd5; end
            9'h036, 9'h074: begin key_kind = K_DIGIT; key_digit = 4'd6; end
            9'h03D, 9'h06C: begin key_kind = K_DIGIT; key_digit = 4'd7; end
            9'h03E, 9'h075: begin key_kind = K_DIGIT; key_digit = 4'd8; end
            9'h046, 9'h07D: begin key_kind = K_DIGIT; key_digit = 4'd9; end
            9'h05A, 9'h15A: key_kind = K_ENTER;
            9'h066:         key_kind = K_BS;
            9'h076:         key_kind = K_ESC;
            default:        key_kind = K_NONE;
        endcase
    end

    // Only recognised makes in IDLE take the lock; everything else leaves it untouched.
    assign accept   = key_valid && key_make && !locked && (key_kind != K_NONE) && (state == IDLE);
    assign shift_in = (entry_bcd << 4) | EW'(key_digit);
    // Most significant nibble first; unused upper nibbles are zero and contribute nothing.
    assign acc_next = acc * AW'(10) + AW'(conv_sr[EW-1 -: 4]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            entry_bcd   <= '0;
            digit_count <= '0;
            busy        <= 1'b0;
            value_out   <= '0;
            value_valid <= 1'b0;
            value_err   <= 1'b0;
            locked      <= 1'b0;
            lock_code   <= '0;
            conv_sr     <= '0;
            conv_cnt    <= '0;
            acc         <= '0;
`ifdef ENTRY_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            value_valid <= 1'b0;
            value_err   <= 1'b0;

            if (key_valid && !key_make && locked && (key_code == lock_code))
                locked <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        locked    <= 1'b1;
                        lock_code <= key_code;
                        case (key_kind)
                            K_DIGIT: begin
                                if (digit_count != FULL_CNT) begin
                                    entry_bcd   <= shift_in;
                                    digit_count <= digit_count + CW'(1);
                                end else if (FULL_MODE != 0) begin
                                    entry_bcd   <= shift_in;
                                end
                            end
                            K_BS: begin
                                if (digit_count != '0) begin
                                    entry_bcd   <= entry_bcd >> 4;
                                    digit_count <= digit_count - CW'(1);
                                end
                            end
                            K_ESC: begin
                                entry_bcd   <= '0;
                                digit_count <= '0;
                            end
                            K_ENTER: begin
                                if (digit_count == '0) begin
                                    value_err <= 1'b1;
                                end else begin
                                    state    <= CONVERT;
                                    busy     <= 1'b1;
                                    acc      <= '0;
                                    conv_sr  <= entry_bcd;
                                    conv_cnt <= FULL_CNT - CW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
`ifdef ENTRY_TIMEOUT_EN
                    if (accept) begin
                        idle_cnt <= '0;
                    end else if (digit_count != '0) begin
                        if (idle_cnt == TO_LAST) begin
                            entry_bcd   <= '0;
                            digit_count <= '0;
                            idle_cnt    <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + TW'(1);
                        end
                    end
`endif
                end

                CONVERT: begin
                    acc     <= acc_next;
                    conv_sr <= conv_sr << 4;
                    if (conv_cnt == '0)
                        state <= CHECK;
                    else
                        conv_cnt <= conv_cnt - CW'(1);
`ifdef ENTRY_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                end

                CHECK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if ((acc >= MIN_A) && (acc <= MAX_A)) begin
                        value_out   <= acc[VALUE_W-1:0];
                        value_valid <= 1'b1;
                        entry_bcd   <= '0;
                        digit_count <= '0;
                    end else begin
                        value_err <= 1'b1;
                    end
`ifdef ENTRY_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_numeric_entry_ctrl.sv
// Directed self-checking bench for numeric_entry_ctrl at its default parameters,
// with TIMEOUT_CYCLES reduced so the optional idle clear is observable.
module tb_numeric_entry_ctrl;

    localparam int ND   = 2;
    localparam int VW   = 7;
    localparam int FULL = 0;
    localparam int TO   = 16;

    logic          clk;
    logic          rst_n;
    logic          key_valid;
    logic [8:0]    key_code;
    logic          key_make;
    logic [4*ND-1:0] entry_bcd;
    logic [1:0]    digit_count;
    logic          busy;
    logic [VW-1:0] value_out;
    logic          value_valid;
    logic          value_err;

    int n_cmp = 0;
    int n_err = 0;

    numeric_entry_ctrl #(
        .NUM_DIGITS(ND), .VALUE_W(VW), .MIN_VALUE(1), .MAX_VALUE(25),
        .FULL_MODE(FULL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_make(key_make), .entry_bcd(entry_bcd), .digit_count(digit_count),
        .busy(busy), .value_out(value_out), .value_valid(value_valid),
        .value_err(value_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one event; it is consumed at the next edge and this returns just after it.
    task automatic send(input logic [8:0] code, input logic make);
        key_valid = 1'b1;
        key_code  = code;
        key_make  = make;
        tick();
        key_valid = 1'b0;
        key_code  = 9'h000;
        key_make  = 1'b0;
    endtask

    task automatic press(input logic [8:0] code);
        send(code, 1'b1);
        send(code, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({entry_bcd, digit_count, busy, value_out, value_valid, value_err} !== '0) begin
            n_err++;
            $display("FAIL reset: entry=%h cnt=%0d busy=%b val=%0d vv=%b ve=%b, all required 0",
                     entry_bcd, digit_count, busy, value_out, value_valid, value_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_entry();
        press(9'h016);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h01, 2'd1}) begin
            n_err++;
            $display("FAIL basic_d1: entry=%h cnt=%0d required 01/1", entry_bcd, digit_count);
        end
        press(9'h072);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h12, 2'd2}) begin
            n_err++;
            $display("FAIL basic_d2: entry=%h cnt=%0d required 12/2", entry_bcd, digit_count);
        end
        send(9'h05A, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            n_cmp++;
            if ({busy, value_valid, value_err} !== 3'b100) begin
                n_err++;
                $display("FAIL basic_busy[T+%0d]: busy=%b vv=%b ve=%b required 1/0/0",
                         i, busy, value_valid, value_err);
            end
            tick();
        end
        n_cmp++;
        if ({busy, value_valid, value_err, value_out, entry_bcd, digit_count} !==
            {1'b0, 1'b1, 1'b0, 7'd12, 8'h00, 2'd0}) begin
            n_err++;
            $display("FAIL basic_result: busy=%b vv=%b ve=%b val=%0d entry=%h cnt=%0d required 0/1/0/12/00/0",
                     busy, value_valid, value_err, value_out, entry_bcd, digit_count);
        end
        tick();
        n_cmp++;
        if ({value_valid, value_err, value_out} !== {1'b0, 1'b0, 7'd12}) begin
            n_err++;
            $display("FAIL basic_pulse_end: vv=%b ve=%b val=%0d required 0/0/12",
                     value_valid, value_err, value_out);
        end
        send(9'h05A, 1'b0);
    endtask

    task automatic test_press_lock();
        send(9'h016, 1'b1);
        send(9'h01E, 1'b1);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h01, 2'd1}) begin
            n_err++;
            $display("FAIL lock_hold: entry=%h cnt=%0d required 01/1", entry_bcd, digit_count);
        end
        send(9'h016, 1'b0);
        send(9'h01E, 1'b1);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h12, 2'd2}) begin
            n_err++;
            $display("FAIL lock_release: entry=%h cnt=%0d required 12/2", entry_bcd, digit_count);
        end
        send(9'h01E, 1'b0);
        press(9'h076);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h00, 2'd0}) begin
            n_err++;
            $display("FAIL esc_clear: entry=%h cnt=%0d required 00/0", entry_bcd, digit_count);
        end
    endtask

    task automatic test_range_err();
        press(9'h026);
        press(9'h045);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h30, 2'd2}) begin
            n_err++;
            $display("FAIL range_entry: entry=%h cnt=%0d required 30/2", entry_bcd, digit_count);
        end
        send(9'h05A, 1'b1);
        tick(); tick(); tick();
        n_cmp++;
        if ({busy, value_valid, value_err, value_out, entry_bcd, digit_count} !==
            {1'b0, 1'b0, 1'b1, 7'd12, 8'h30, 2'd2}) begin
            n_err++;
            $display("FAIL range_high: busy=%b vv=%b ve=%b val=%0d entry=%h cnt=%0d required 0/0/1/12/30/2",
                     busy, value_valid, value_err, value_out, entry_bcd, digit_count);
        end
        tick();
        n_cmp++;
        if (value_err !== 1'b0) begin
            n_err++;
            $display("FAIL range_err_width: ve=%b required 0", value_err);
        end
        send(9'h05A, 1'b0);
        press(9'h066);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h03, 2'd1}) begin
            n_err++;
            $display("FAIL backspace: entry=%h cnt=%0d required 03/1", entry_bcd, digit_count);
        end
        send(9'h15A, 1'b1);
        tick(); tick(); tick();
        n_cmp++;
        if ({value_valid, value_err, value_out, entry_bcd, digit_count} !==
            {1'b1, 1'b0, 7'd3, 8'h00, 2'd0}) begin
            n_err++;
            $display("FAIL range_fix: vv=%b ve=%b val=%0d entry=%h cnt=%0d required 1/0/3/00/0",
                     value_valid, value_err, value_out, entry_bcd, digit_count);
        end
        send(9'h15A, 1'b0);
    endtask

    task automatic test_zero_and_esc();
        press(9'h045);
        press(9'h070);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h00, 2'd2}) begin
            n_err++;
            $display("FAIL zero_entry: entry=%h cnt=%0d required 00/2", entry_bcd, digit_count);
        end
        send(9'h05A, 1'b1);
        tick(); tick(); tick();
        n_cmp++;
        if ({value_valid, value_err, value_out, digit_count} !== {1'b0, 1'b1, 7'd3, 2'd2}) begin
            n_err++;
            $display("FAIL range_low: vv=%b ve=%b val=%0d cnt=%0d required 0/1/3/2",
                     value_valid, value_err, value_out, digit_count);
        end
        send(9'h05A, 1'b0);
        press(9'h076);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h00, 2'd0}) begin
            n_err++;
            $display("FAIL zero_esc: entry=%h cnt=%0d required 00/0", entry_bcd, digit_count);
        end
        send(9'h05A, 1'b1);
        n_cmp++;
        if ({busy, value_valid, value_err} !== 3'b001) begin
            n_err++;
            $display("FAIL empty_enter: busy=%b vv=%b ve=%b required 0/0/1", busy, value_valid, value_err);
        end
        tick();
        n_cmp++;
        if ({busy, value_valid, value_err} !== 3'b000) begin
            n_err++;
            $display("FAIL empty_enter_end: busy=%b vv=%b ve=%b required 0/0/0", busy, value_valid, value_err);
        end
        send(9'h05A, 1'b0);
    endtask

    task automatic test_full();
        logic [7:0] exp_e;
        press(9'h016);
        press(9'h01E);
        press(9'h026);
        exp_e = (FULL != 0) ? 8'h23 : 8'h12;
        n_cmp++;
        if ({entry_bcd, digit_count} !== {exp_e, 2'd2}) begin
            n_err++;
            $display("FAIL full: entry=%h cnt=%0d required %h/2", entry_bcd, digit_count, exp_e);
        end
        press(9'h066);
        exp_e = (FULL != 0) ? 8'h02 : 8'h01;
        n_cmp++;
        if ({entry_bcd, digit_count} !== {exp_e, 2'd1}) begin
            n_err++;
            $display("FAIL full_bs: entry=%h cnt=%0d required %h/1", entry_bcd, digit_count, exp_e);
        end
        press(9'h076);
    endtask

    task automatic test_ignored();
        press(9'h066);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h00, 2'd0}) begin
            n_err++;
            $display("FAIL bs_empty: entry=%h cnt=%0d required 00/0", entry_bcd, digit_count);
        end
        send(9'h01C, 1'b1);
        send(9'h116, 1'b1);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h00, 2'd0}) begin
            n_err++;
            $display("FAIL ignored_codes: entry=%h cnt=%0d required 00/0", entry_bcd, digit_count);
        end
        send(9'h016, 1'b1);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h01, 2'd1}) begin
            n_err++;
            $display("FAIL ignored_no_lock: entry=%h cnt=%0d required 01/1", entry_bcd, digit_count);
        end
        send(9'h016, 1'b0);
        send(9'h01C, 1'b0);
        press(9'h076);
    endtask

    task automatic test_digit_table();
        logic [8:0] codes [20];
        codes = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046,
                  9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B, 9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};
        for (int i = 0; i < 20; i++) begin
            press(9'h076);
            press(codes[i]);
            n_cmp++;
            if ({entry_bcd, digit_count} !== {4'h0, 4'(i % 10), 2'd1}) begin
                n_err++;
                $display("FAIL digit_code_%h: entry=%h cnt=%0d required 0%0d/1",
                         codes[i], entry_bcd, digit_count, i % 10);
            end
        end
        press(9'h076);
        press(9'h069);
        press(9'h07D);
        send(9'h15A, 1'b1);
        tick(); tick(); tick();
        n_cmp++;
        if ({value_valid, value_out} !== {1'b1, 7'd19}) begin
            n_err++;
            $display("FAIL keypad_value: vv=%b val=%0d required 1/19", value_valid, value_out);
        end
        send(9'h15A, 1'b0);
    endtask

    task automatic test_busy_drop();
        press(9'h01E);
        press(9'h016);
        send(9'h05A, 1'b1);
        send(9'h05A, 1'b0);
        send(9'h026, 1'b1);
        n_cmp++;
        if ({busy, entry_bcd, digit_count} !== {1'b1, 8'h21, 2'd2}) begin
            n_err++;
            $display("FAIL busy_drop: busy=%b entry=%h cnt=%0d required 1/21/2", busy, entry_bcd, digit_count);
        end
        tick();
        n_cmp++;
        if ({value_valid, value_out, entry_bcd, digit_count} !== {1'b1, 7'd21, 8'h00, 2'd0}) begin
            n_err++;
            $display("FAIL busy_result: vv=%b val=%0d entry=%h cnt=%0d required 1/21/00/0",
                     value_valid, value_out, entry_bcd, digit_count);
        end
        send(9'h026, 1'b0);
        press(9'h026);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h03, 2'd1}) begin
            n_err++;
            $display("FAIL busy_no_lock: entry=%h cnt=%0d required 03/1", entry_bcd, digit_count);
        end
    endtask

    task automatic test_idle();
`ifdef ENTRY_TIMEOUT_EN
        repeat (TO - 2) tick();
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h03, 2'd1}) begin
            n_err++;
            $display("FAIL timeout_early: entry=%h cnt=%0d required 03/1", entry_bcd, digit_count);
        end
        tick();
        n_cmp++;
        if ({entry_bcd, digit_count, value_valid, value_err} !== {8'h00, 2'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_clear: entry=%h cnt=%0d vv=%b ve=%b required 00/0/0/0",
                     entry_bcd, digit_count, value_valid, value_err);
        end
`else
        repeat (40) tick();
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h03, 2'd1}) begin
            n_err++;
            $display("FAIL persist: entry=%h cnt=%0d required 03/1", entry_bcd, digit_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        press(9'h076);
        press(9'h01E);
        press(9'h016);
        send(9'h05A, 1'b1);
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({entry_bcd, digit_count, busy, value_out, value_valid, value_err} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: entry=%h cnt=%0d busy=%b val=%0d vv=%b ve=%b, all required 0",
                     entry_bcd, digit_count, busy, value_out, value_valid, value_err);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({busy, value_valid, value_err} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_mid_quiet[%0d]: busy=%b vv=%b ve=%b required 0/0/0",
                         i, busy, value_valid, value_err);
            end
            tick();
        end
        press(9'h016);
        n_cmp++;
        if ({entry_bcd, digit_count} !== {8'h01, 2'd1}) begin
            n_err++;
            $display("FAIL reset_unlock: entry=%h cnt=%0d required 01/1", entry_bcd, digit_count);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 9'h000;
        key_make  = 1'b0;
        #1;
        test_reset();
        test_basic_entry();
        test_press_lock();
        test_range_err();
        test_zero_and_esc();
        test_full();
        test_ignored();
        test_digit_table();
        test_busy_drop();
        test_idle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
